// File: rtl/ami_r_mc_pkg.sv
// ami_r_mc_pkg: shared AXI encodings and width helpers for the multi-channel read master
package ami_r_mc_pkg;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_e;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_e;
    function automatic int chw_f(input int nch);
        return $clog2(nch);
    endfunction
    function automatic int uiw_f(input int iw, input int nch);
        return iw - $clog2(nch);
    endfunction
endpackage

// File: rtl/ami_r_mc_if.sv
// ami_r_mc_if: AXI AR and R channel bundle between the read master and the fabric
interface ami_r_mc_if
    import ami_r_mc_pkg::*;
#(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3
);
    logic [AXI_IW-1:0] ARID;
    logic [AXI_AW-1:0] ARADDR;
    logic [AXI_LW-1:0] ARLEN;
    logic [AXI_SW-1:0] ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [AXI_IW-1:0] RID;
    logic [AXI_DW-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    modport master (output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                    input ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
    modport slave  (input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
endinterface

// File: rtl/ami_r_mc_sfifo.sv
// ami_sfifo: synchronous first-word-fall-through FIFO, depth D (power of 2)
module ami_sfifo #(
    parameter int W = 8,
    parameter int D = 16,
    localparam int AW = $clog2(D)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          we,
    input  logic          re,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   cnt
);
    logic [W-1:0] mem [D];
    logic [AW:0]  wp, rp;
    assign cnt   = wp - rp;
    assign empty = cnt == '0;
    assign full  = cnt[AW];
    assign q     = mem[rp[AW-1:0]];
    // pointers advance on accepted push/pop; pushes into a full FIFO are ignored
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (we && !full) wp <= wp + {{AW{1'b0}}, 1'b1};
            if (re && !empty) rp <= rp + {{AW{1'b0}}, 1'b1};
        end
    end
    // storage written only on accepted push
    always_ff @(posedge ACLK) begin
        if (we && !full) mem[wp[AW-1:0]] <= d;
    end
endmodule

// File: rtl/ami_r_mc.sv
// ami_r_mc: multi-channel AXI read master (RR AR arbiter, outstanding limits, RID-routed R FIFOs); optional AMI_RERR_EN adds sticky error flags
module ami_r_mc
    import ami_r_mc_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3,
    parameter int AMI_OD = 4,
    parameter int AMI_TD = 8,
    parameter int AMI_XD = 16,
    localparam int CHW = chw_f(NCH),
    localparam int UIW = uiw_f(AXI_IW, NCH)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    ami_r_mc_if.master        axi,
    input  logic [UIW-1:0]    usr_arid    [NCH],
    input  logic [AXI_AW-1:0] usr_araddr  [NCH],
    input  logic [AXI_LW-1:0] usr_arlen   [NCH],
    input  logic [AXI_SW-1:0] usr_arsize  [NCH],
    input  logic [1:0]        usr_arburst [NCH],
    input  logic [NCH-1:0]    usr_arvalid,
    output logic [NCH-1:0]    usr_arready,
    output logic [UIW-1:0]    usr_rid     [NCH],
    output logic [AXI_DW-1:0] usr_rdata   [NCH],
    output logic [1:0]        usr_rresp   [NCH],
    output logic [NCH-1:0]    usr_rlast,
    output logic [NCH-1:0]    usr_rvalid,
    input  logic [NCH-1:0]    usr_rready
`ifdef AMI_RERR_EN
    ,
    output logic [NCH-1:0]    usr_rerr,
    input  logic [NCH-1:0]    usr_rerr_clr
`endif
);
    localparam int CW = $clog2(AMI_TD + 1);
    localparam int FW = UIW + AXI_DW + 3;
    logic [CW-1:0]           ost [NCH];
    logic [CW-1:0]           tot;
    logic [CHW-1:0]          ptr, gch, k, rch;
    logic [NCH-1:0]          elig, push, full, empty;
    logic [FW-1:0]           fq [NCH];
    logic [$clog2(AMI_XD):0] fcnt [NCH];
    logic                    gv, ld, rok, rhs, rdec;
    assign ld  = !axi.ARVALID || axi.ARREADY;
    assign rch = axi.RID[AXI_IW-1 -: CHW];
    if (NCH == (1 << CHW)) begin : g_pow2
        assign rok = 1'b1;
    end else begin : g_npow2
        assign rok = rch < CHW'(NCH);
    end
    assign axi.RREADY  = ARESETn && (!rok || !full[rch]);
    assign rhs         = axi.RVALID && axi.RREADY;
    assign rdec        = rhs && rok && axi.RLAST && ost[rch] != '0;
    assign usr_arready = gv ? (NCH'(1) << gch) : '0;
    // channel may be granted when requesting, within both budgets, and the AR slot can load
    always_comb begin
        elig = '0;
        for (int c = 0; c < NCH; c++)
            elig[c] = ARESETn && ld && usr_arvalid[c] && ost[c] < CW'(AMI_OD) && tot < CW'(AMI_TD);
    end
    // round-robin pick: first eligible channel starting at ptr (one past the last grant)
    always_comb begin
        gv  = 1'b0;
        gch = '0;
        k   = '0;
        for (int i = 0; i < NCH; i++) begin
            k = CHW'((int'(ptr) + i) % NCH);
            if (!gv && elig[k]) begin
                gv  = 1'b1;
                gch = k;
            end
        end
    end
    // AR slot: reloads when empty or draining, otherwise holds payload stable
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            axi.ARVALID <= 1'b0;
            axi.ARID    <= '0;
            axi.ARADDR  <= '0;
            axi.ARLEN   <= '0;
            axi.ARSIZE  <= '0;
            axi.ARBURST <= '0;
        end else if (ld) begin
            axi.ARVALID <= gv;
            if (gv) begin
                axi.ARID    <= {gch, usr_arid[gch]};
                axi.ARADDR  <= usr_araddr[gch];
                axi.ARLEN   <= usr_arlen[gch];
                axi.ARSIZE  <= usr_arsize[gch];
                axi.ARBURST <= usr_arburst[gch];
            end
        end
    end
    // burst budgets: +1 on grant, -1 on routed RLAST, never below zero
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ptr <= '0;
            tot <= '0;
            for (int c = 0; c < NCH; c++) ost[c] <= '0;
        end else begin
            if (gv) ptr <= (gch == CHW'(NCH - 1)) ? '0 : gch + CHW'(1);
            tot <= tot + CW'(gv) - CW'(rdec);
            for (int c = 0; c < NCH; c++)
                ost[c] <= ost[c] + CW'(gv && gch == CHW'(c)) - CW'(rdec && rch == CHW'(c));
        end
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign push[c] = rhs && rok && rch == CHW'(c);
        ami_sfifo #(.W(FW), .D(AMI_XD)) u_fifo (
            .ACLK    (ACLK),
            .ARESETn (ARESETn),
            .we      (push[c]),
            .re      (ARESETn && usr_rready[c] && !empty[c]),
            .d       ({axi.RID[UIW-1:0], axi.RDATA, axi.RRESP, axi.RLAST}),
            .q       (fq[c]),
            .full    (full[c]),
            .empty   (empty[c]),
            .cnt     (fcnt[c])
        );
        assign {usr_rid[c], usr_rdata[c], usr_rresp[c], usr_rlast[c]} = fq[c];
        assign usr_rvalid[c] = ARESETn && fcnt[c] != '0;
    end
`ifdef AMI_RERR_EN
    logic [NCH-1:0] eset;
    // error sources: error response or orphan RLAST per channel; stray tags charged to ch0
    always_comb begin
        eset = '0;
        for (int c = 0; c < NCH; c++)
            eset[c] = push[c] && (axi.RRESP[1] || (axi.RLAST && ost[c] == '0));
        eset[0] = eset[0] || (rhs && !rok);
    end
    // sticky flags; clear takes priority over a same-cycle set
    always_ff @(posedge ACLK) begin
        if (!ARESETn) usr_rerr <= '0;
        else usr_rerr <= (usr_rerr | eset) & ~usr_rerr_clr;
    end
`endif
endmodule

// File: tb/tb_ami_r_mc.sv
// tb_ami_r_mc: table-driven and directed sequence checks for ami_r_mc
module tb_ami_r_mc;
    import ami_r_mc_pkg::*;
    localparam int NCH = 4, DW = 128, AW = 32, IW = 8, LW = 8, SW = 3, UIW = 6;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;
    ami_r_mc_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) axi ();
    logic [UIW-1:0] usr_arid    [NCH];
    logic [AW-1:0]  usr_araddr  [NCH];
    logic [LW-1:0]  usr_arlen   [NCH];
    logic [SW-1:0]  usr_arsize  [NCH];
    logic [1:0]     usr_arburst [NCH];
    logic [UIW-1:0] usr_rid     [NCH];
    logic [DW-1:0]  usr_rdata   [NCH];
    logic [1:0]     usr_rresp   [NCH];
    logic [NCH-1:0] usr_arvalid, usr_arready, usr_rlast, usr_rvalid, usr_rready;
`ifdef AMI_RERR_EN
    logic [NCH-1:0] usr_rerr, usr_rerr_clr;
`endif
    ami_r_mc #(.NCH(NCH), .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
               .AMI_OD(4), .AMI_TD(8), .AMI_XD(16)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .axi         (axi),
        .usr_arid    (usr_arid),
        .usr_araddr  (usr_araddr),
        .usr_arlen   (usr_arlen),
        .usr_arsize  (usr_arsize),
        .usr_arburst (usr_arburst),
        .usr_arvalid (usr_arvalid),
        .usr_arready (usr_arready),
        .usr_rid     (usr_rid),
        .usr_rdata   (usr_rdata),
        .usr_rresp   (usr_rresp),
        .usr_rlast   (usr_rlast),
        .usr_rvalid  (usr_rvalid),
        .usr_rready  (usr_rready)
`ifdef AMI_RERR_EN
        ,
        .usr_rerr     (usr_rerr),
        .usr_rerr_clr (usr_rerr_clr)
`endif
    );

    typedef struct packed {
        logic [3:0] avm;
        logic       rv;
        logic [1:0] rch;
        logic       rl;
        logic [3:0] gnt;
        logic       arv;
        logic [1:0] arc;
    } vec_t;
    vec_t tv [13];
    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [7:0] xid(input int c);
        return {2'(c), 6'(16 + c)};
    endfunction

    task automatic idle();
        usr_arvalid  = '0;
        usr_rready   = '1;
        axi.ARREADY  = 1'b1;
        axi.RVALID   = 1'b0;
        axi.RID      = '0;
        axi.RDATA    = '0;
        axi.RRESP    = '0;
        axi.RLAST    = 1'b0;
`ifdef AMI_RERR_EN
        usr_rerr_clr = '0;
`endif
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        idle();
        usr_arvalid = '1;
        axi.RVALID  = 1'b1;
        axi.RLAST   = 1'b1;
        repeat (3) tick();
        chk("rst_arvalid", axi.ARVALID, 0);
        chk("rst_araddr", axi.ARADDR, 0);
        chk("rst_rready", axi.RREADY, 0);
        chk("rst_arready", usr_arready, 0);
        chk("rst_rvalid", usr_rvalid, 0);
        idle();
        ARESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            usr_arid[c]    = 6'(16 + c);
            usr_araddr[c]  = 32'((c + 1) * 32'h1000);
            usr_arlen[c]   = 8'(c + 3);
            usr_arsize[c]  = 3'd4;
            usr_arburst[c] = BURST_INCR;
        end
        //           avm   rv rch rl  gnt  arv arc
        tv[0]  = '{4'hF, 0, 0, 0, 4'h1, 1, 0};
        tv[1]  = '{4'hF, 0, 0, 0, 4'h2, 1, 1};
        tv[2]  = '{4'hF, 0, 0, 0, 4'h4, 1, 2};
        tv[3]  = '{4'hF, 0, 0, 0, 4'h8, 1, 3};
        tv[4]  = '{4'hF, 0, 0, 0, 4'h1, 1, 0};
        tv[5]  = '{4'hF, 0, 0, 0, 4'h2, 1, 1};
        tv[6]  = '{4'hF, 0, 0, 0, 4'h4, 1, 2};
        tv[7]  = '{4'hF, 0, 0, 0, 4'h8, 1, 3};
        tv[8]  = '{4'hF, 0, 0, 0, 4'h0, 0, 0};
        tv[9]  = '{4'hF, 1, 1, 1, 4'h0, 0, 0};
        tv[10] = '{4'hF, 1, 2, 1, 4'h1, 1, 0};
        tv[11] = '{4'hF, 0, 0, 0, 4'h2, 1, 1};
        tv[12] = '{4'hF, 0, 0, 0, 4'h0, 0, 0};

        // round-robin order, total budget of 8, release and grant+RLAST in one cycle
        do_reset();
        for (int i = 0; i < 13; i++) begin
            usr_arvalid = tv[i].avm;
            axi.RVALID  = tv[i].rv;
            axi.RID     = {tv[i].rch, 6'h0};
            axi.RLAST   = tv[i].rl;
            #1;
            chk($sformatf("v%0d_gnt", i), usr_arready, tv[i].gnt);
            if (tv[i].rv) chk($sformatf("v%0d_rready", i), axi.RREADY, 1);
            tick();
            chk($sformatf("v%0d_arvalid", i), axi.ARVALID, tv[i].arv);
            if (tv[i].arv) chk($sformatf("v%0d_arid", i), axi.ARID, xid(tv[i].arc));
        end

        // per-channel limit of 4 on ch1, other channel still served
        do_reset();
        for (int i = 0; i < 4; i++) begin
            usr_arvalid = 4'b0010;
            #1;
            chk($sformatf("od_gnt%0d", i), usr_arready, 4'b0010);
            tick();
        end
        usr_arvalid = 4'b0011;
        #1;
        chk("od_block5", usr_arready, 4'b0001);
        tick();
        usr_arvalid = 4'b0010;
        axi.RVALID  = 1'b1;
        axi.RID     = {2'd1, 6'h0};
        axi.RLAST   = 1'b1;
        #1;
        chk("od_still_blocked", usr_arready, 4'b0000);
        tick();
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'b0;
        #1;
        chk("od_release_gnt", usr_arready, 4'b0010);
        tick();
        chk("od_release_arid", axi.ARID, xid(1));

        // ARREADY stall: payload held, then a single transfer
        do_reset();
        usr_arvalid = 4'b0001;
        axi.ARREADY = 1'b0;
        #1;
        chk("st_gnt", usr_arready, 4'b0001);
        tick();
        usr_araddr[0] = 32'hDEAD0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("st_arvalid%0d", i), axi.ARVALID, 1);
            chk($sformatf("st_arid%0d", i), axi.ARID, xid(0));
            chk($sformatf("st_araddr%0d", i), axi.ARADDR, 32'h1000);
            chk($sformatf("st_nogrant%0d", i), usr_arready, 0);
            tick();
        end
        usr_araddr[0] = 32'h1000;
        usr_arvalid   = '0;
        axi.ARREADY   = 1'b1;
        #1;
        chk("st_xfer_valid", axi.ARVALID, 1);
        tick();
        chk("st_after_xfer", axi.ARVALID, 0);

        // ch2 FIFO fills to 16; beat 17 back-pressured; ch0 still accepted
        do_reset();
        usr_rready = 4'b1010;
        for (int b = 0; b < 17; b++) begin
            axi.RVALID = 1'b1;
            axi.RID    = {2'd2, 6'(b)};
            axi.RDATA  = 128'(b + 100);
            #1;
            chk($sformatf("ff_rready%0d", b), axi.RREADY, b < 16);
            if (b == 0) chk("ff_empty_before", usr_rvalid[2], 0);
            tick();
            if (b == 0) chk("ff_visible_next", usr_rvalid[2], 1);
        end
        axi.RID   = {2'd0, 6'h3F};
        axi.RDATA = 128'hABC;
        axi.RRESP = 2'b01;
        axi.RLAST = 1'b1;
        #1;
        chk("ff_ch0_rready", axi.RREADY, 1);
        chk("ff_ch0_empty", usr_rvalid[0], 0);
        tick();
        idle();
        usr_rready = 4'b1010;
        #1;
        chk("ff_ch0_valid", usr_rvalid[0], 1);
        chk("ff_ch0_data", usr_rdata[0], 128'hABC);
        chk("ff_ch0_rid", usr_rid[0], 6'h3F);
        chk("ff_ch0_rresp", usr_rresp[0], 2'b01);
        chk("ff_ch0_rlast", usr_rlast[0], 1);
        usr_rready = 4'b1111;
        for (int b = 0; b < 16; b++) begin
            #1;
            chk($sformatf("ff_pop_valid%0d", b), usr_rvalid[2], 1);
            chk($sformatf("ff_pop_data%0d", b), usr_rdata[2], 128'(b + 100));
            chk($sformatf("ff_pop_rid%0d", b), usr_rid[2], 6'(b));
            tick();
        end
        chk("ff_drained", usr_rvalid[2], 0);

`ifdef AMI_RERR_EN
        // sticky error flag, clear priority, orphan RLAST without counter underflow
        do_reset();
        axi.RVALID = 1'b1;
        axi.RID    = {2'd3, 6'h0};
        axi.RRESP  = 2'b10;
        tick();
        idle();
        #1;
        chk("er_set", usr_rerr, 4'b1000);
        tick();
        chk("er_sticky", usr_rerr, 4'b1000);
        usr_rerr_clr = 4'b1000;
        tick();
        usr_rerr_clr = '0;
        #1;
        chk("er_cleared", usr_rerr, 4'b0000);
        axi.RVALID   = 1'b1;
        axi.RID      = {2'd3, 6'h0};
        axi.RRESP    = 2'b11;
        usr_rerr_clr = 4'b1000;
        tick();
        idle();
        #1;
        chk("er_clr_wins", usr_rerr, 4'b0000);
        axi.RVALID = 1'b1;
        axi.RID    = {2'd1, 6'h0};
        axi.RLAST  = 1'b1;
        tick();
        idle();
        #1;
        chk("er_orphan_last", usr_rerr, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            usr_arvalid = 4'b0010;
            #1;
            chk($sformatf("er_ost_gnt%0d", i), usr_arready, 4'b0010);
            tick();
        end
        #1;
        chk("er_ost_limit", usr_arready, 4'b0000);
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
